// File: rtl/donut_frame_sequencer_if.sv
// ROM read port between the donut frame sequencer (master) and the 4-bit frame ROM (slave).
interface donut_frame_sequencer_if;
  logic        rom_cen_o;
  logic [31:0] rom_addr_o;
  logic [3:0]  rom_data_i;

  modport master (output rom_cen_o, output rom_addr_o, input rom_data_i);
  modport slave  (input rom_cen_o, input rom_addr_o, output rom_data_i);
endinterface

// File: rtl/donut_frame_sequencer.sv
// Donut animation sequencer: VGA coordinates -> frame ROM address -> 12-bit RGB, latency 3.
// Optional macro DONUT_PALETTE_EN adds a writable 16x12 palette; otherwise shades map to a grey ramp.
//
// state   | meaning
// SHOW    | current frame on screen, counting vsync rising edges while run_i=1
// ADVANCE | single cycle in vblank that steps frame_o and frame_base
module donut_frame_sequencer #(
  parameter int          IMG_W       = 320,
  parameter int          IMG_H       = 220,
  parameter int          NUM_FRAMES  = 10,
  parameter int          SCALE_SHIFT = 1,
  parameter int          X_OFF       = 0,
  parameter int          Y_OFF       = 20,
  parameter int          FRAME_HOLD  = 6,
  parameter logic [11:0] BG_COLOR    = 12'h000
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           run_i,
  input  logic                           de_i,
  input  logic                           hsync_i,
  input  logic                           vsync_i,
  input  logic [9:0]                     x_i,
  input  logic [9:0]                     y_i,
  donut_frame_sequencer_if.master        rom,
  input  logic                           pal_we_i,
  input  logic [3:0]                     pal_addr_i,
  input  logic [11:0]                    pal_data_i,
  output logic [11:0]                    rgb_o,
  output logic                           de_o,
  output logic                           hsync_o,
  output logic                           vsync_o,
  output logic [3:0]                     frame_o
);

  localparam logic [31:0] X_OFF_L      = 32'(X_OFF);
  localparam logic [31:0] Y_OFF_L      = 32'(Y_OFF);
  localparam logic [31:0] WIN_W        = 32'(IMG_W << SCALE_SHIFT);
  localparam logic [31:0] WIN_H        = 32'(IMG_H << SCALE_SHIFT);
  localparam logic [31:0] ROW_STRIDE   = 32'(IMG_W);
  localparam logic [31:0] FRAME_STRIDE = 32'(IMG_W * IMG_H);
  localparam logic [31:0] S_MASK       = 32'((1 << SCALE_SHIFT) - 1);
  localparam int          HOLD_W       = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(FRAME_HOLD - 1);
  localparam logic [3:0]        FRAME_LAST = 4'(NUM_FRAMES - 1);

  typedef enum logic {SHOW, ADVANCE} state_t;

  state_t            state;
  logic [HOLD_W-1:0] hold_cnt;
  logic [31:0]       frame_base;
  logic [31:0]       row_base;
  logic              vsync_q;
  logic [1:0]        win_q;
  logic [2:0]        de_q, hs_q, vs_q;
  logic [31:0]       x_rel, y_rel;
  logic              in_win, vs_rise, row_end;
  logic [11:0]       shade_rgb;

  // Unsigned wrap makes coordinates left of / above the window fail the upper-bound test.
  assign x_rel   = {22'd0, x_i} - X_OFF_L;
  assign y_rel   = {22'd0, y_i} - Y_OFF_L;
  assign in_win  = de_i && (x_rel < WIN_W) && (y_rel < WIN_H);
  assign vs_rise = vsync_i && !vsync_q;
  assign row_end = in_win && (x_rel == WIN_W - 32'd1) && ((y_rel & S_MASK) == S_MASK);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= SHOW;
      hold_cnt   <= '0;
      frame_o    <= '0;
      frame_base <= '0;
      vsync_q    <= 1'b0;
    end else begin
      vsync_q <= vsync_i;
      case (state)
        SHOW: begin
          if (vs_rise && run_i) begin
            if (hold_cnt == HOLD_LAST) begin
              hold_cnt <= '0;
              state    <= ADVANCE;
            end else begin
              hold_cnt <= hold_cnt + HOLD_W'(1);
            end
          end
        end
        ADVANCE: begin
          state <= SHOW;
          if (frame_o == FRAME_LAST) begin
            frame_o    <= '0;
            frame_base <= '0;
          end else begin
            frame_o    <= frame_o + 4'd1;
            frame_base <= frame_base + FRAME_STRIDE;
          end
        end
        default: state <= SHOW;
      endcase
    end
  end

  // A vsync edge coinciding with the last-column step must leave the new frame at row 0.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      row_base <= '0;
    end else if (vs_rise) begin
      row_base <= '0;
    end else if (row_end) begin
      row_base <= row_base + ROW_STRIDE;
    end
  end

`ifdef DONUT_PALETTE_EN
  logic [11:0] pal [16];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 16; i++) pal[i] <= {3{4'(i)}};
    end else if (pal_we_i) begin
      pal[pal_addr_i] <= pal_data_i;
    end
  end

  assign shade_rgb = pal[rom.rom_data_i];
`else
  logic unused_pal;
  assign unused_pal = &{1'b0, pal_we_i, pal_addr_i, pal_data_i};
  assign shade_rgb  = {3{rom.rom_data_i}};
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rom.rom_cen_o  <= 1'b0;
      rom.rom_addr_o <= '0;
      win_q          <= '0;
      de_q           <= '0;
      hs_q           <= '0;
      vs_q           <= '0;
      rgb_o          <= '0;
    end else begin
      rom.rom_cen_o <= in_win;
      if (in_win) rom.rom_addr_o <= frame_base + row_base + (x_rel >> SCALE_SHIFT);
      win_q <= {win_q[0], in_win};
      de_q  <= {de_q[1:0], de_i};
      hs_q  <= {hs_q[1:0], hsync_i};
      vs_q  <= {vs_q[1:0], vsync_i};
      if (!de_q[1])      rgb_o <= '0;
      else if (win_q[1]) rgb_o <= shade_rgb;
      else               rgb_o <= BG_COLOR;
    end
  end

  assign de_o    = de_q[2];
  assign hsync_o = hs_q[2];
  assign vsync_o = vs_q[2];

endmodule

// File: tb/tb_donut_frame_sequencer.sv
// Randomized raster bench for donut_frame_sequencer with an arithmetic reference model.
// Honours DONUT_PALETTE_EN the same way as the design.
module tb_donut_frame_sequencer;

  localparam int          IMG_W      = 320;
  localparam int          IMG_H      = 220;
  localparam int          NUM_FRAMES = 10;
  localparam int          S          = 1;
  localparam int          X_OFF      = 0;
  localparam int          Y_OFF      = 20;
  localparam int          FRAME_HOLD = 6;
  localparam logic [11:0] BG         = 12'h000;

  logic        clk_i = 1'b0;
  logic        rst_i, run_i, de_i, hsync_i, vsync_i;
  logic [9:0]  x_i, y_i;
  logic        pal_we_i;
  logic [3:0]  pal_addr_i;
  logic [11:0] pal_data_i;
  logic [11:0] rgb_o;
  logic        de_o, hsync_o, vsync_o;
  logic [3:0]  frame_o;

  donut_frame_sequencer_if rom_bus ();

  donut_frame_sequencer dut (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .run_i      (run_i),
    .de_i       (de_i),
    .hsync_i    (hsync_i),
    .vsync_i    (vsync_i),
    .x_i        (x_i),
    .y_i        (y_i),
    .rom        (rom_bus),
    .pal_we_i   (pal_we_i),
    .pal_addr_i (pal_addr_i),
    .pal_data_i (pal_data_i),
    .rgb_o      (rgb_o),
    .de_o       (de_o),
    .hsync_o    (hsync_o),
    .vsync_o    (vsync_o),
    .frame_o    (frame_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic        de, hs, vs, cen;
    logic [31:0] addr;
    logic [11:0] rgb;
  } rec_t;

  rec_t        ring [8];
  int          cyc = 8;
  int          errors = 0;
  int          checks = 0;
  int          run_cnt = 0;
  bit          vs_prev = 0;
  logic [31:0] last_addr = '0;
  bit          rst_v, run_v;
  bit          force_en = 0;
  logic [3:0]  force_val = 4'h0;
  bit          wr_en = 0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
`ifdef DONUT_PALETTE_EN
  logic [11:0] pal_m [16];
`endif

  function automatic logic [3:0] rom_fn(input logic [31:0] a);
    return a[3:0] ^ a[7:4] ^ a[12:9];
  endfunction

  function automatic logic [11:0] shade_map(input logic [3:0] s);
`ifdef DONUT_PALETTE_EN
    return pal_m[s];
`else
    return {s, s, s};
`endif
  endfunction

  function automatic int model_frame();
    return (run_cnt / FRAME_HOLD) % NUM_FRAMES;
  endfunction

  // Registered ROM: answers the cycle after the sequencer asserts rom_cen_o.
  always @(posedge clk_i)
    if (rom_bus.rom_cen_o)
      rom_bus.rom_data_i <= force_en ? force_val : rom_fn(rom_bus.rom_addr_o);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // One pixel clock: check outputs owed by earlier cycles, then apply and model this cycle.
  task automatic drive(input bit de, input bit hs, input bit vs, input int x, input int y);
    rec_t r;
    int   xr, yr;
    @(negedge clk_i);
    cyc++;
    r = ring[(cyc - 1) % 8];
    chk("rom_cen", rom_bus.rom_cen_o, r.cen);
    chk("rom_addr", rom_bus.rom_addr_o, r.addr);
    r = ring[(cyc - 3) % 8];
    chk("de_o", de_o, r.de);
    chk("hsync_o", hsync_o, r.hs);
    chk("vsync_o", vsync_o, r.vs);
    chk("rgb", rgb_o, r.rgb);

    rst_i = rst_v; run_i = run_v;
    de_i = de; hsync_i = hs; vsync_i = vs;
    x_i = 10'(x); y_i = 10'(y);
    pal_we_i = wr_en; pal_addr_i = wr_addr; pal_data_i = wr_data;

    r = '0;
    if (rst_v) begin
      ring[(cyc - 1) % 8] = '0;
      ring[(cyc - 2) % 8] = '0;
      last_addr = '0;
      vs_prev   = 0;
      run_cnt   = 0;
`ifdef DONUT_PALETTE_EN
      for (int i = 0; i < 16; i++) pal_m[i] = {3{4'(i)}};
`endif
    end else begin
      xr = x - X_OFF;
      yr = y - Y_OFF;
      r.de = de; r.hs = hs; r.vs = vs;
      r.cen = de && xr >= 0 && xr < (IMG_W << S) && yr >= 0 && yr < (IMG_H << S);
      if (r.cen)
        last_addr = 32'(model_frame() * IMG_W * IMG_H + (yr >> S) * IMG_W + (xr >> S));
      r.addr = last_addr;
      r.rgb  = !de ? 12'h000 : (r.cen ? shade_map(force_en ? force_val : rom_fn(last_addr)) : BG);
      if (vs && !vs_prev && run_v) run_cnt++;
      vs_prev = vs;
`ifdef DONUT_PALETTE_EN
      if (wr_en) pal_m[wr_addr] = wr_data;
`endif
    end
    ring[cyc % 8] = r;
    wr_en = 0;
  endtask

  // Sparse raster: each line ends on the last window column so row stepping is exercised.
  task automatic do_frame(input int y0, input int y1, input int max_px, input bit coll);
    int np, x;
    for (int i = 0; i < 3; i++) begin
      if (coll && i == 0) drive(1, 0, 1, 639, 21);
      else drive(0, 1'($urandom_range(0, 1)), 1, $urandom_range(0, 1023), $urandom_range(0, 1023));
    end
    drive(0, 0, 0, 0, 0);
    chk("frame_o", frame_o, 32'(model_frame()));
    for (int y = y0; y <= y1; y++) begin
      np = $urandom_range(0, max_px);
      for (int p = 0; p < np; p++) begin
        x = $urandom_range(0, 700);
        if (x == 639) x = 640;
        drive($urandom_range(0, 3) != 0, 0, 0, x, y);
      end
      drive(1, 0, 0, 640, y);
      drive(1, 0, 0, 639, y);
      drive(0, 1, 0, $urandom_range(0, 1023), y);
    end
  endtask

  initial begin
    int frozen;
    for (int i = 0; i < 8; i++) ring[i] = '0;
`ifdef DONUT_PALETTE_EN
    for (int i = 0; i < 16; i++) pal_m[i] = {3{4'(i)}};
`endif
    rst_i = 1; run_i = 1; de_i = 0; hsync_i = 0; vsync_i = 0; x_i = '0; y_i = '0;
    pal_we_i = 0; pal_addr_i = '0; pal_data_i = '0;
    rst_v = 1; run_v = 1;
    repeat (2) @(posedge clk_i);
    repeat (4) drive(0, 0, 0, 0, 0);
    chk("rst_frame", frame_o, 32'd0);
    rst_v = 0;

    // First window pixel after reset, shade 9, then palette write and same-cycle write/read.
    force_en = 1; force_val = 4'h9;
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 20);
    repeat (3) drive(0, 0, 0, 0, 0);
    wr_en = 1; wr_addr = 4'h9; wr_data = 12'hF80;
    drive(0, 0, 0, 0, 0);
    repeat (2) drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 2, 20);
    drive(0, 0, 0, 0, 0);
    wr_en = 1; wr_addr = 4'h9; wr_data = 12'h0AB;
    drive(0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    drive(1, 0, 0, 4, 20);
    repeat (4) drive(0, 0, 0, 0, 0);
    force_en = 0;

    // Reset in the middle of a live line, then finish rows 20..22.
    for (int i = 0; i < 20; i++) begin
      rst_v = (i == 8 || i == 9);
      drive(1, 0, 0, 10 + i, 20);
    end
    rst_v = 0;
    drive(1, 0, 0, 639, 20);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 100, 21);
    drive(1, 0, 0, 639, 21);
    drive(0, 1, 0, 0, 0);
    drive(1, 0, 0, 2, 22);
    drive(1, 0, 0, 639, 22);
    drive(0, 1, 0, 0, 0);

    frozen = 0;
    for (int f = 0; f < 100; f++) begin
      if (f < 65)      run_v = 1;
      else if (f < 75) run_v = 0;
      else             run_v = ($urandom_range(0, 3) != 0);
      if (f == 65) frozen = model_frame();
      do_frame(16 + $urandom_range(0, 4), 20 + $urandom_range(0, 10), 6, 0);
      if (f == 74) chk("freeze", frame_o, 32'(frozen));
    end

    run_v = 1;
    do_frame(0, 479, 1, 0);
    do_frame(20, 20, 4, 0);
    do_frame(20, 24, 6, 1);
    repeat (6) drive(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
